rgb_ycbcr_pipe: RTL and testbench

Parametrised colour-space front end for the ISP chain. It accepts RGB565 or RGB888 pixels with DVP-style timing (hsync/vsync/de) and produces one of four 24-bit output formats: gray, YCbCr 4:4:4, RGB888 bypass or binary threshold. It uses BT.601 full-range integer arithmetic with rounding and saturation. It sits between the camera/frame-buffer reader and the edge-detection window generator, and replaces the fixed 565-to-Y converter.

---
 rtl/rgb_ycbcr_pipe_pkg.sv | 56 +++++
 rtl/rgb_ycbcr_pipe_if.sv | 16 +
 rtl/rgb_ycbcr_pipe_sync_delay.sv | 36 +++
 rtl/rgb_ycbcr_pipe.sv | 147 ++++++++++++++
 tb/tb_rgb_ycbcr_pipe.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/rgb_ycbcr_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isp_pkg
// Description : BT.601 full-range coefficients, biases, mode encodings and
//               shared arithmetic helpers for the ISP colour front end.
// Revision    : 1.0
// ============================================================================
package isp_pkg;

    localparam logic [7:0] KY_R  = 8'd77;
    localparam logic [7:0] KY_G  = 8'd150;
    localparam logic [7:0] KY_B  = 8'd29;
    localparam logic [7:0] KCB_R = 8'd43;
    localparam logic [7:0] KCB_G = 8'd85;
    localparam logic [7:0] KCB_B = 8'd128;
    localparam logic [7:0] KCR_R = 8'd128;
    localparam logic [7:0] KCR_G = 8'd107;
    localparam logic [7:0] KCR_B = 8'd21;

    localparam int RND   = 128;
    localparam int CBIAS = 32896;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'd0,
        MODE_YCC  = 2'd1,
        MODE_RGB  = 2'd2,
        MODE_BIN  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [15:0] yr, yg, yb;
        logic [15:0] cbr, cbg, cbb;
        logic [15:0] crr, crg, crb;
    } prod_t;

    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
        return {8'd0, a} * {8'd0, b};
    endfunction

    // Drop the 8 fraction bits, then saturate the signed result to [0,255].
    function automatic logic [7:0] sat8(input logic signed [17:0] acc);
        logic [9:0] q;
        q = acc[17:8];
        if (q[9])      return 8'd0;
        else if (q[8]) return 8'hFF;
        else           return q[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_ycbcr_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : rgb_ycbcr_pipe_if
// Description : DVP-style pixel bus (hsync/vsync/de/data).
// Revision    : 1.0
// ============================================================================
interface rgb_ycbcr_pipe_if;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] data;

    modport master (output hsync, vsync, de, data);
    modport slave  (input  hsync, vsync, de, data);
endinterface
`default_nettype wire

// File: rtl/rgb_ycbcr_pipe_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : isp_sync_delay
// Description : N-deep, W-wide shift register with synchronous reset.
// Revision    : 1.0
// ============================================================================
module isp_sync_delay #(
    parameter int N = 3,
    parameter int W = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [W-1:0] d_i,
    output logic      [W-1:0] q_o
);

    logic [N*W-1:0] sr_q;

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) sr_q <= '0;
                else     sr_q <= d_i;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) sr_q <= '0;
                else     sr_q <= {sr_q[(N-1)*W-1:0], d_i};
            end
        end
    endgenerate

    assign q_o = sr_q[N*W-1 -: W];

endmodule
`default_nettype wire

// File: rtl/rgb_ycbcr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rgb_ycbcr_pipe
// Description : 3-stage RGB565/888 to gray / YCbCr / RGB / binary converter.
// Revision    : 1.0
// ============================================================================
module rgb_ycbcr_pipe
    import isp_pkg::*;
#(
    parameter int         IN_FMT  = 0,
    parameter bit         VS_POL  = 1'b1,
    parameter logic [7:0] THR_RST = 8'd128
) (
    input  wire logic              clk,
    input  wire logic              rst,
    rgb_ycbcr_pipe_if.slave        in_if,
    rgb_ycbcr_pipe_if.master       out_if,
    input  wire logic [1:0]        cfg_mode,
    input  wire logic [7:0]        cfg_thresh,
    output logic      [1:0]        act_mode
);

    rgb_t  w_pix;
    mode_e w_mode_d;
    logic  [7:0] w_thr_d;
    logic  w_vs_edge;
    prod_t w_prod_d;

    mode_e act_mode_q;
    logic  [7:0] act_thr_q;
    logic  vsync_prev_q;

    prod_t s1_prod_q;
    rgb_t  s1_pix_q;
    mode_e s1_mode_q;
    logic  [7:0] s1_thr_q;

    logic signed [17:0] s2_y_q, s2_cb_q, s2_cr_q;
    rgb_t  s2_pix_q;
    mode_e s2_mode_q;
    logic  [7:0] s2_thr_q;

    logic  [23:0] w_out_d;
    logic  [23:0] out_data_q;
    logic  [2:0]  w_sync;

    generate
        if (IN_FMT == 0) begin : g_fmt565
            logic [7:0] w_unused;
            assign w_unused = in_if.data[23:16];
            assign w_pix.r  = {in_if.data[15:11], in_if.data[15:13]};
            assign w_pix.g  = {in_if.data[10:5],  in_if.data[10:9]};
            assign w_pix.b  = {in_if.data[4:0],   in_if.data[4:2]};
        end else begin : g_fmt888
            assign w_pix = in_if.data;
        end
    endgenerate

    // The edge pixel itself already sees the new configuration.
    assign w_vs_edge = (vsync_prev_q != VS_POL) && (in_if.vsync == VS_POL);
    assign w_mode_d  = w_vs_edge ? mode_e'(cfg_mode) : act_mode_q;
    assign w_thr_d   = w_vs_edge ? cfg_thresh : act_thr_q;

    always_comb begin
        w_prod_d     = '0;
        w_prod_d.yr  = mul8(w_pix.r, KY_R);
        w_prod_d.yg  = mul8(w_pix.g, KY_G);
        w_prod_d.yb  = mul8(w_pix.b, KY_B);
        w_prod_d.cbr = mul8(w_pix.r, KCB_R);
        w_prod_d.cbg = mul8(w_pix.g, KCB_G);
        w_prod_d.cbb = mul8(w_pix.b, KCB_B);
        w_prod_d.crr = mul8(w_pix.r, KCR_R);
        w_prod_d.crg = mul8(w_pix.g, KCR_G);
        w_prod_d.crb = mul8(w_pix.b, KCR_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_mode_q   <= MODE_GRAY;
            act_thr_q    <= THR_RST;
            vsync_prev_q <= ~VS_POL;
            s1_prod_q    <= '0;
            s1_pix_q     <= '0;
            s1_mode_q    <= MODE_GRAY;
            s1_thr_q     <= '0;
            s2_y_q       <= '0;
            s2_cb_q      <= '0;
            s2_cr_q      <= '0;
            s2_pix_q     <= '0;
            s2_mode_q    <= MODE_GRAY;
            s2_thr_q     <= '0;
            out_data_q   <= '0;
        end else begin
            act_mode_q   <= w_mode_d;
            act_thr_q    <= w_thr_d;
            vsync_prev_q <= in_if.vsync;

            s1_prod_q    <= w_prod_d;
            s1_pix_q     <= w_pix;
            s1_mode_q    <= w_mode_d;
            s1_thr_q     <= w_thr_d;

            // 18-bit modular sums; the bias keeps every real result non-negative.
            s2_y_q  <= 18'(s1_prod_q.yr) + 18'(s1_prod_q.yg) + 18'(s1_prod_q.yb) + 18'(RND);
            s2_cb_q <= 18'(s1_prod_q.cbb) - 18'(s1_prod_q.cbr) - 18'(s1_prod_q.cbg) + 18'(CBIAS);
            s2_cr_q <= 18'(s1_prod_q.crr) - 18'(s1_prod_q.crg) - 18'(s1_prod_q.crb) + 18'(CBIAS);
            s2_pix_q     <= s1_pix_q;
            s2_mode_q    <= s1_mode_q;
            s2_thr_q     <= s1_thr_q;

            out_data_q   <= w_out_d;
        end
    end

    always_comb begin
        logic [7:0] y, cb, cr;
        y       = sat8(s2_y_q);
        cb      = sat8(s2_cb_q);
        cr      = sat8(s2_cr_q);
        w_out_d = '0;
        case (s2_mode_q)
            MODE_GRAY: w_out_d = {y, y, y};
            MODE_YCC:  w_out_d = {y, cb, cr};
            MODE_RGB:  w_out_d = s2_pix_q;
            MODE_BIN:  w_out_d = (y >= s2_thr_q) ? 24'hFFFFFF : 24'h000000;
            default:   w_out_d = '0;
        endcase
    end

    isp_sync_delay #(
        .N (3),
        .W (3)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d_i ({in_if.hsync, in_if.vsync, in_if.de}),
        .q_o (w_sync)
    );

    assign out_if.hsync = w_sync[2];
    assign out_if.vsync = w_sync[1];
    assign out_if.de    = w_sync[0];
    assign out_if.data  = out_data_q & {24{w_sync[0]}};
    assign act_mode     = act_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_ycbcr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_ycbcr_pipe
// Description : Directed self-checking bench for rgb_ycbcr_pipe (565 and 888).
// Revision    : 1.0
// ============================================================================
module tb_rgb_ycbcr_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_thresh;
    logic [1:0] act565, act888;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_ycbcr_pipe_if pin ();
    rgb_ycbcr_pipe_if po565 ();
    rgb_ycbcr_pipe_if po888 ();

    rgb_ycbcr_pipe #(.IN_FMT(0), .VS_POL(1'b1), .THR_RST(8'd128)) dut565 (
        .clk        (clk),
        .rst        (rst),
        .in_if      (pin),
        .out_if     (po565),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .act_mode   (act565)
    );

    rgb_ycbcr_pipe #(.IN_FMT(1), .VS_POL(1'b1), .THR_RST(8'd128)) dut888 (
        .clk        (clk),
        .rst        (rst),
        .in_if      (pin),
        .out_if     (po888),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .act_mode   (act888)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic h, input logic v, input logic de, input logic [23:0] d);
        pin.hsync = h;
        pin.vsync = v;
        pin.de    = de;
        pin.data  = d;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One valid pixel, then idle; returns on the edge where it is at the output.
    task automatic send(input logic [23:0] d);
        drive(1'b0, 1'b0, 1'b1, d);
        tick();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        tick();
    endtask

    task automatic pulse_vsync();
        drive(1'b0, 1'b1, 1'b0, 24'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
    endtask

    logic [2:0] hist [0:22];

    initial begin
        rst        = 1'b1;
        cfg_mode   = 2'd1;
        cfg_thresh = 8'd0;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        tick();
        chk("rst_data",  po565.data,  24'h0);
        chk("rst_de",    po565.de,    24'h0);
        chk("rst_hsync", po565.hsync, 24'h0);
        chk("rst_vsync", po565.vsync, 24'h0);
        chk("rst_mode",  act565,      24'h0);
        rst = 1'b0;

        pulse_vsync();
        chk("mode_load", act565, 24'd1);

        send(24'h00FFFF);
        chk("ycc_white", po565.data, 24'hFF8080);
        chk("ycc_white_de", po565.de, 24'd1);
        tick();
        chk("idle_de",   po565.de,   24'd0);
        chk("idle_data", po565.data, 24'h0);

        send(24'h00F800);
        chk("ycc_red", po565.data, 24'h4D55FF);
        send(24'h00001F);
        chk("ycc_blue", po565.data, 24'h1DFF6B);

        // Mid-frame request must not take effect.
        cfg_mode = 2'd2;
        send(24'h00FFFF);
        chk("midframe_hold", po565.data, 24'hFF8080);
        chk("midframe_mode", act565, 24'd1);

        // Edge and pixel in the same cycle: gray white, not YCC white.
        cfg_mode = 2'd0;
        drive(1'b0, 1'b1, 1'b1, 24'h00FFFF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        tick();
        chk("edge_pixel", po565.data, 24'hFFFFFF);
        chk("edge_mode", act565, 24'd0);

        cfg_mode = 2'd2;
        pulse_vsync();
        chk("mode_rgb", act888, 24'd2);
        send(24'h123456);
        chk("bypass888", po888.data, 24'h123456);

        // Y = (77*18 + 150*52 + 29*86 + 128) >> 8 = 11808 >> 8 = 46.
        cfg_mode = 2'd0;
        pulse_vsync();
        send(24'h123456);
        chk("gray888", po888.data, 24'h2E2E2E);

        cfg_mode   = 2'd3;
        cfg_thresh = 8'd77;
        pulse_vsync();
        send(24'h00F800);
        chk("bin_eq", po565.data, 24'hFFFFFF);
        cfg_thresh = 8'd78;
        send(24'h00F800);
        chk("bin_hold", po565.data, 24'hFFFFFF);
        pulse_vsync();
        send(24'h00F800);
        chk("bin_below", po565.data, 24'h000000);

        for (int i = 0; i < 23; i++) begin
            if (i >= 3) begin
                chk("stream_sync", {21'd0, po565.hsync, po565.vsync, po565.de}, {21'd0, hist[i-3]});
                if (!hist[i-3][0]) chk("stream_blank", po565.data, 24'h0);
            end
            hist[i] = (i < 20) ? 3'($urandom) : 3'd0;
            drive(hist[i][2], hist[i][1], hist[i][0], 24'($urandom));
            tick();
        end

        cfg_mode = 2'd1;
        pulse_vsync();
        chk("pre_rst_mode", act565, 24'd1);
        drive(1'b1, 1'b0, 1'b1, 24'h00FFFF);
        tick();
        drive(1'b1, 1'b0, 1'b1, 24'h00F800);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 24'h00001F);
        tick();
        chk("mid_rst_data",  po565.data,  24'h0);
        chk("mid_rst_de",    po565.de,    24'h0);
        chk("mid_rst_hsync", po565.hsync, 24'h0);
        chk("mid_rst_vsync", po565.vsync, 24'h0);
        chk("mid_rst_mode",  act565,      24'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 24'h00FFFF);
        tick();
        chk("post_rst_c1", po565.de, 24'd0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        chk("post_rst_c2", po565.de, 24'd0);
        tick();
        chk("post_rst_de",   po565.de,   24'd1);
        chk("post_rst_data", po565.data, 24'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
